hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Pipeline hazard controller that drives the hold and clear inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It watches the ID stage operands and the control fields leaving ID/EX (memory-read bit, rt, divide flag, branch outcome). From these it inserts load-use bubbles, freezes the front end while a multi-cycle divide occupies EX, and squashes wrong-path instructions on a taken branch. It sits beside the pipeline registers and is their only source of `enable` and clear.

## Interface

Parameters:
- `DIV_CYCLES`, default 32: number of cycles a divide stays in EX; legal values are 2 or more.
- `CNT_W`, default `$clog2(DIV_CYCLES)`: width of the divide counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_use_rs`, `id_use_rt`  in  1 each  the ID instruction reads rs / rt.
- `ex_memread`  in  1  memory-read bit of the ID/EX M bundle.
- `ex_rt`  in  5  ID/EX rt (load destination).
- `ex_divd`  in  1  ID/EX divide flag.
- `ex_branch_taken`  in  1  branch in EX resolved taken.
- `pc_en`  out  1  PC load enable.
- `if_id_en`  out  1  IF/ID enable.
- `if_id_flush`  out  1  IF/ID synchronous clear.
- `id_ex_en`  out  1  ID/EX enable.
- `id_ex_flush`  out  1  ID/EX synchronous clear (inserts a bubble).
- `ex_mem_flush`  out  1  EX/MEM synchronous clear.
- `div_busy`  out  1  FSM is in state DIV.

## Operation

- FSM states: IDLE and DIV. Register `cnt` is `CNT_W` bits wide.
- `load_use` = `ex_memread` && `ex_rt` != 0 && ((`id_use_rs` && `id_rs` == `ex_rt`) || (`id_use_rt` && `id_rt` == `ex_rt`)).
- In IDLE, the first matching row applies:
  - **Branch:** `ex_branch_taken`=1. Outputs: `pc_en`=1, `if_id_en`=1, `if_id_flush`=1, `id_ex_en`=1, `id_ex_flush`=1. The branch wins over a simultaneous `load_use`.
  - **Divide:** `ex_divd`=1. Outputs: `pc_en`=0, `if_id_en`=0, `id_ex_en`=0, `id_ex_flush`=0, `ex_mem_flush`=1. Load `cnt` with `DIV_CYCLES`-2, then go to DIV.
  - **Load-use:** `load_use`=1. Outputs: `pc_en`=0, `if_id_en`=0, `id_ex_en`=1, `id_ex_flush`=1. This is a single bubble; state stays IDLE.
  - **Otherwise:** all enables are 1 and all flushes are 0.
- In DIV, `ex_branch_taken` and `load_use` are ignored.
  - While `cnt` != 0: hold the same outputs as the IDLE divide row, and decrement `cnt`.
  - When `cnt` == 0 (release cycle): all enables are 1, `ex_mem_flush`=0, and the next state is IDLE. The divide leaves EX on this edge.
  - If `load_use` is true against the instruction held in ID during the release cycle, it is evaluated one cycle later in IDLE.
- `div_busy` is 1 exactly when the state is DIV.

## Timing

- All hazard outputs are combinational from the current state and inputs. They are consumed by the register enables at the next rising edge, so the effective latency is 0 cycles.
- A divide occupies EX for exactly `DIV_CYCLES` cycles: the IDLE detect cycle plus `DIV_CYCLES`-1 DIV cycles, the last of which is the release cycle. With `DIV_CYCLES`=2, DIV is entered with `cnt`=0 and releases immediately.
- Behaviour while `rst`=0, regardless of inputs:
  - State is IDLE and `cnt` is 0.
  - `pc_en`, `if_id_en` and `id_ex_en` are 0.
  - `if_id_flush`, `id_ex_flush`, `ex_mem_flush` and `div_busy` are 0.
- Reset asserted mid-DIV aborts the divide stall immediately.
- After `rst` deasserts, normal IDLE behaviour resumes at the first edge.
- Back-to-back divides: the release cycle returns to IDLE. If the next EX instruction is also a divide, IDLE detects it and starts a new full sequence with no gap.

## Configuration

- `HAZARD_DIV_STALL_EN` defined:
  - The DIV state, `cnt` and the divide row are compiled in.
- `HAZARD_DIV_STALL_EN` undefined:
  - `ex_divd` is ignored.
  - The FSM reduces to IDLE only and `cnt` is removed.
  - `div_busy` is tied to 0 and `ex_mem_flush` is tied to 0.
  - Branch and load-use behaviour is unchanged.

## Structure

- Shared package `hazard_pkg` holds:
  - the state enum `{IDLE, DIV}`;
  - constant `M_MEMREAD_BIT`, the index of the read bit in the 3-bit M bundle;
  - constant `REG_ZERO` = 5'd0.
- Sub-module `div_stall_counter` holds the load/decrement counter. Its signals: `load`, `load_val`, `dec`, `zero`, with async active-low reset.
- Hazard priority logic and the FSM stay in the top module.

## Test plan

- **Load-use:** `ex_memread`=1, `ex_rt`=5, `id_rs`=5, `id_use_rs`=1 → in that cycle `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1. The next cycle (no hazard) has all enables 1.
- **Load to $0:** `ex_memread`=1, `ex_rt`=0, `id_rs`=0, `id_use_rs`=1 → no stall; enables 1, flushes 0.
- **Divide:** with `DIV_CYCLES`=4, assert `ex_divd`=1 → front-end enables stay 0 for cycles 1–3, `div_busy` is 1 in cycles 2–4, and cycle 4 is the release cycle with all enables 1. The next cycle is IDLE.
- **Branch vs. load-use:** `ex_branch_taken`=1 together with a `load_use` match → `pc_en`=1, `if_id_flush`=1, `id_ex_flush`=1, no stall.
- **Reset mid-divide:** drive `rst` low in DIV with `cnt`=10 → `div_busy` goes to 0 and all enables go to 0 immediately. After release, the first cycle with `ex_divd`=0 has all enables 1.
- **Macro off:** with `HAZARD_DIV_STALL_EN` undefined, assert `ex_divd`=1 → enables stay 1 and `div_busy` stays 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    // Position of the read bit inside the 3-bit M control bundle {branch, memread, memwrite}.
    localparam int unsigned M_MEMREAD_BIT = 1;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/div_stall_counter.sv
// Load/decrement down-counter that times a multi-cycle divide occupying EX.
module div_stall_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squash and divide freeze.
// The divide stall (DIV state and counter) is present only when HAZARD_DIV_STALL_EN is defined.
//
//   state | meaning
//   IDLE  | normal flow; branch / divide / load-use rows evaluated in priority order
//   DIV   | divide occupies EX; front end frozen until the counter reaches zero
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = $clog2(DIV_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_divd,
    input  logic       ex_branch_taken,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       if_id_flush,
    output logic       id_ex_en,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       div_busy
);

    logic load_use;

    assign load_use = ex_memread && (ex_rt != REG_ZERO) &&
                      ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));

`ifdef HAZARD_DIV_STALL_EN
    state_t state, next_state;
    logic   cnt_load, cnt_dec, cnt_zero;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    div_stall_counter #(
        .W (CNT_W)
    ) u_div_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(DIV_CYCLES - 2)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign div_busy = (state == DIV);
`else
    logic unused_cfg;

    assign unused_cfg = clk ^ ex_divd ^ (^CNT_W'(DIV_CYCLES));
    assign div_busy   = 1'b0;
`endif

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
`ifdef HAZARD_DIV_STALL_EN
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
`endif
        if (!rst) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
        end else begin
`ifdef HAZARD_DIV_STALL_EN
            if (state == DIV) begin
                // Branch and load-use are deliberately ignored while the divide holds EX.
                if (!cnt_zero) begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_flush = 1'b1;
                    cnt_dec      = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end else
`endif
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
`ifdef HAZARD_DIV_STALL_EN
            else if (ex_divd) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                cnt_load     = 1'b1;
                next_state   = DIV;
            end
`endif
            else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

endmodule
